uart_rx_variable_baud: RTL



---
 rtl/uart_rx_variable_baud_if.sv | 46 ++++
 rtl/uart_rx_variable_baud.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_variable_baud_if.sv
// uart_rx_variable_baud_if
// Bundles the serial line, the bit-period controls and the receiver outputs
// of uart_rx_variable_baud into one interface.
//   master : the side that drives the RX pin and the period commands and
//            consumes the received bytes (board glue or testbench)
//   slave  : the receiver itself
// Signals:
//   i_UART_RX        serial line, idles high
//   i_Set_Period     one-cycle pulse, loads i_Period
//   i_Period         new period value (clocks per bit)
//   i_Faster         one-cycle pulse, halves the period
//   i_Slower         one-cycle pulse, doubles the period
//   i_Autobaud_Arm   one-cycle pulse, arms auto-baud measurement
//   o_Period         current period register
//   o_Byte           last good byte
//   o_Valid          one-cycle pulse when o_Byte updates
//   o_Frame_Err      one-cycle pulse on a low stop bit
//   o_Busy           receiver not idle
//   o_Autobaud_Done  one-cycle pulse when a measured period is loaded
interface uart_rx_variable_baud_if #(
    parameter int DATA_BITS = 8,
    parameter int PERIOD_W  = 20
);
    logic                 i_UART_RX;
    logic                 i_Set_Period;
    logic [PERIOD_W-1:0]  i_Period;
    logic                 i_Faster;
    logic                 i_Slower;
    logic                 i_Autobaud_Arm;
    logic [PERIOD_W-1:0]  o_Period;
    logic [DATA_BITS-1:0] o_Byte;
    logic                 o_Valid;
    logic                 o_Frame_Err;
    logic                 o_Busy;
    logic                 o_Autobaud_Done;

    modport master (
        output i_UART_RX, i_Set_Period, i_Period, i_Faster, i_Slower, i_Autobaud_Arm,
        input  o_Period, o_Byte, o_Valid, o_Frame_Err, o_Busy, o_Autobaud_Done
    );

    modport slave (
        input  i_UART_RX, i_Set_Period, i_Period, i_Faster, i_Slower, i_Autobaud_Arm,
        output o_Period, o_Byte, o_Valid, o_Frame_Err, o_Busy, o_Autobaud_Done
    );
endinterface

// File: rtl/uart_rx_variable_baud.sv
// uart_rx_variable_baud
// UART receiver (8N1-style, DATA_BITS data bits, LSB first) whose bit period
// is a runtime register. The period can be loaded, halved (clamped to
// MIN_PERIOD) or doubled (held once the MSB is set). The period in force for
// a frame is latched at the start edge, so commands never disturb a frame in
// flight. Start bits shorter than half a period are rejected as glitches; a
// low stop bit gives a frame-error pulse and the receiver waits for the line
// to return high.
// Optional feature, macro AUTOBAUD_EN: after i_Autobaud_Arm the next start
// bit is measured and, if plausible, loaded as the new period; the rest of
// the calibration character (0x55) is skipped.
// Ports:
//   i_Clk    system clock, rising edge
//   i_Rst_L  asynchronous active-low reset
//   bus      uart_rx_variable_baud_if.slave (line, period controls, outputs)
module uart_rx_variable_baud #(
    parameter int CLK_HZ         = 25000000,
    parameter int DATA_BITS      = 8,
    parameter int PERIOD_W       = 20,
    parameter int DEFAULT_PERIOD = 217,
    parameter int MIN_PERIOD     = 4
) (
    input logic                   i_Clk,
    input logic                   i_Rst_L,
    uart_rx_variable_baud_if.slave bus
);
    localparam int BIT_W = $clog2(DATA_BITS) + 1;
    localparam int unused_clk_hz_s = CLK_HZ;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
`ifdef AUTOBAUD_EN
        S_MEASURE   = 3'd5,
        S_SKIP      = 3'd6,
`endif
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t               state_r;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic [PERIOD_W-1:0]  period_r;
    logic [PERIOD_W-1:0]  period_next_s;
    logic [PERIOD_W-1:0]  half_period_s;
    logic [PERIOD_W-1:0]  pa_r;
    logic [PERIOD_W-1:0]  half_pa_s;
    logic [PERIOD_W-1:0]  cnt_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] byte_r;
    logic                 valid_r;
    logic                 frame_err_r;
    logic                 busy_r;
`ifdef AUTOBAUD_EN
    logic                 armed_r;
    logic                 ovf_r;
    logic                 ab_done_r;
    logic                 ab_load_s;

    // A measurement is accepted only if it did not overflow and is usable
    assign ab_load_s = (state_r == S_MEASURE) && rx_sync_r && !ovf_r &&
                       (cnt_r >= PERIOD_W'(MIN_PERIOD));
`else
    logic                 unused_arm_s;
    assign unused_arm_s = bus.i_Autobaud_Arm;
`endif

    assign half_period_s = period_r >> 1;
    assign half_pa_s     = pa_r >> 1;

    // Two-flop synchroniser for the asynchronous RX pin, idles high
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= bus.i_UART_RX;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Next period: measurement load, then Set > Faster > Slower
    always_comb begin
        period_next_s = period_r;
`ifdef AUTOBAUD_EN
        if (ab_load_s) begin
            period_next_s = cnt_r;
        end else
`endif
        if (bus.i_Set_Period) begin
            if (bus.i_Period >= PERIOD_W'(MIN_PERIOD)) begin
                period_next_s = bus.i_Period;
            end else begin
                period_next_s = period_r;
            end
        end else if (bus.i_Faster) begin
            if (half_period_s < PERIOD_W'(MIN_PERIOD)) begin
                period_next_s = PERIOD_W'(MIN_PERIOD);
            end else begin
                period_next_s = half_period_s;
            end
        end else if (bus.i_Slower) begin
            // Doubling would lose the MSB, so the register holds instead
            if (period_r[PERIOD_W-1]) begin
                period_next_s = period_r;
            end else begin
                period_next_s = period_r << 1;
            end
        end else begin
            period_next_s = period_r;
        end
    end

    // Period register
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            period_r <= PERIOD_W'(DEFAULT_PERIOD);
        end else begin
            period_r <= period_next_s;
        end
    end

    // Receive FSM with registered byte, pulse and busy outputs
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r     <= S_IDLE;
            pa_r        <= PERIOD_W'(DEFAULT_PERIOD);
            cnt_r       <= '0;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            byte_r      <= '0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef AUTOBAUD_EN
            armed_r     <= 1'b0;
            ovf_r       <= 1'b0;
            ab_done_r   <= 1'b0;
`endif
        end else begin
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
`ifdef AUTOBAUD_EN
            ab_done_r   <= 1'b0;
            if (bus.i_Autobaud_Arm) begin
                armed_r <= 1'b1;
            end
`endif
            case (state_r)
                S_IDLE: begin
                    if (!rx_sync_r) begin
                        // period_r (not period_next_s) so a same-cycle command
                        // does not affect this frame
                        pa_r      <= period_r;
                        cnt_r     <= '0;
                        bit_cnt_r <= '0;
                        busy_r    <= 1'b1;
`ifdef AUTOBAUD_EN
                        if (armed_r) begin
                            armed_r <= 1'b0;
                            ovf_r   <= 1'b0;
                            cnt_r   <= PERIOD_W'(1);
                            state_r <= S_MEASURE;
                        end else begin
                            state_r <= S_START;
                        end
`else
                        state_r   <= S_START;
`endif
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_r == half_pa_s) begin
                        cnt_r <= '0;
                        if (rx_sync_r) begin
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= S_DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r + PERIOD_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_r == pa_r - PERIOD_W'(1)) begin
                        cnt_r     <= '0;
                        shift_r   <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        if (bit_cnt_r == BIT_W'(DATA_BITS - 1)) begin
                            state_r <= S_STOP;
                        end
                    end else begin
                        cnt_r <= cnt_r + PERIOD_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_r == pa_r - PERIOD_W'(1)) begin
                        cnt_r <= '0;
                        if (rx_sync_r) begin
                            byte_r  <= shift_r;
                            valid_r <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= S_IDLE;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_r <= cnt_r + PERIOD_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low line (break) must not be mistaken for a start bit
                    if (rx_sync_r) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= S_WAIT_HIGH;
                    end
                end
`ifdef AUTOBAUD_EN
                S_MEASURE: begin
                    if (rx_sync_r) begin
                        ab_done_r <= ab_load_s;
                        pa_r      <= ovf_r ? {PERIOD_W{1'b1}} : cnt_r;
                        cnt_r     <= '0;
                        bit_cnt_r <= '0;
                        state_r   <= S_SKIP;
                    end else if (cnt_r == {PERIOD_W{1'b1}}) begin
                        ovf_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + PERIOD_W'(1);
                    end
                end
                S_SKIP: begin
                    // Let the rest of the calibration character pass unseen
                    if (cnt_r == pa_r - PERIOD_W'(1)) begin
                        cnt_r     <= '0;
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        if (bit_cnt_r == BIT_W'(DATA_BITS - 1)) begin
                            state_r <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_r <= cnt_r + PERIOD_W'(1);
                    end
                end
`endif
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Period      = period_r;
    assign bus.o_Byte        = byte_r;
    assign bus.o_Valid       = valid_r;
    assign bus.o_Frame_Err   = frame_err_r;
    assign bus.o_Busy        = busy_r;
`ifdef AUTOBAUD_EN
    assign bus.o_Autobaud_Done = ab_done_r;
`else
    assign bus.o_Autobaud_Done = 1'b0;
`endif
endmodule
